// File: rtl/sb_arb_pkg.sv
// Shared types and constants for the sideband TX arbiter.
// SB_msg_t mirrors the message enum of the SB codex package.
package sb_arb_pkg;

    localparam int unsigned MAX_REQ      = 8;
    localparam int unsigned WDOG_DEFAULT = 1024;
    localparam int unsigned SB_DATA_W    = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    typedef enum logic [4:0] {
        SB_MSG_NIL,
        SBINIT_OOR,
        SBINIT_DONE_REQ,
        SBINIT_DONE_RESP,
        MBINIT_PARAM_REQ,
        MBINIT_PARAM_RESP,
        MBTRAIN_VALVREF_REQ,
        MBTRAIN_VALVREF_RESP
    } SB_msg_t;

endpackage

// File: rtl/sb_rr_picker.sv
// Combinational round-robin select: first set request strictly after ptr_i, with wrap.
module sb_rr_picker #(
    parameter int unsigned  N_REQ = 4,
    localparam int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic [IDW-1:0]   grant_idx_c,
    output logic             found_c
);

    int unsigned cand;

    always_comb begin
        grant_idx_c = '0;
        found_c     = 1'b0;
        cand        = 0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = 32'(ptr_i) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found_c && req_i[IDW'(cand)]) begin
                found_c     = 1'b1;
                grant_idx_c = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/sb_tx_arbiter.sv
// Round-robin arbiter sharing the SB TX message port among LTSM requesters.
// Optional watchdog abort of a stalled SEND enabled by SB_TX_ARB_WDOG_EN.
module sb_tx_arbiter
    import sb_arb_pkg::*;
#(
    parameter int unsigned  N_REQ       = 4,
    parameter int unsigned  WDOG_CYCLES = WDOG_DEFAULT,
    localparam int unsigned IDW         = $clog2(N_REQ)
) (
    input  logic                   clk_100MHz,
    input  logic                   reset,
    input  logic                   enable_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  SB_msg_t [N_REQ-1:0]    req_msg_i,
    input  logic [N_REQ*64-1:0]    req_data_i,
    output logic [N_REQ-1:0]       req_ack_o,
    output SB_msg_t                SB_TX_msg_o,
    output logic [63:0]            SB_TX_dataBus_o,
    output logic                   SB_TX_msg_valid_o,
    input  logic                   SB_TX_msg_sendNextFlag_i,
    output logic [IDW-1:0]         grant_id_o,
    output logic                   busy_o,
    output logic                   wdog_err_o
);

    arb_state_t        state_q, state_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    SB_msg_t           msg_q, msg_d;
    logic [63:0]       data_q, data_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic              wdog_err_q, wdog_err_d;

    logic [IDW-1:0]    pick_idx_c;
    logic              pick_found_c;
    logic [63:0]       pick_data_c;
    logic              accept_c;
    logic              timeout_c;

    sb_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req_i       (req_valid_i),
        .ptr_i       (rr_ptr_q),
        .grant_idx_c (pick_idx_c),
        .found_c     (pick_found_c)
    );

    // Payload slice of the requester currently selected by the picker
    always_comb begin
        pick_data_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_idx_c == IDW'(i)) begin
                pick_data_c = req_data_i[i*64 +: 64];
            end
        end
    end

    assign accept_c = valid_q & SB_TX_msg_sendNextFlag_i;

`ifdef SB_TX_ARB_WDOG_EN
    localparam int unsigned WCW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    logic [WCW-1:0] wdog_cnt_q, wdog_cnt_d;

    // Counter is held at zero outside SEND, so every SEND starts from zero
    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if (state_q != SEND) begin
            wdog_cnt_d = '0;
        end else if (!accept_c) begin
            wdog_cnt_d = wdog_cnt_q + WCW'(1);
        end
    end

    assign timeout_c = (state_q == SEND) && !accept_c &&
                       (wdog_cnt_q == WCW'(WDOG_CYCLES - 1));

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            wdog_cnt_q <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
        end
    end
`else
    logic [31:0] unused_wdog_cycles_c;

    // Watchdog limit has no effect without the watchdog
    assign unused_wdog_cycles_c = 32'(WDOG_CYCLES);
    assign timeout_c            = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        msg_d      = msg_q;
        data_d     = data_q;
        ack_d      = '0;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        wdog_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i && pick_found_c) begin
                    state_d = SEND;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    msg_d   = req_msg_i[pick_idx_c];
                    data_d  = pick_data_c;
                    grant_d = pick_idx_c;
                end
            end
            SEND: begin
                if (accept_c) begin
                    state_d  = GAP;
                    valid_d  = 1'b0;
                    busy_d   = 1'b0;
                    ack_d    = N_REQ'(1) << grant_q;
                    rr_ptr_d = grant_q;
                end else if (timeout_c) begin
                    state_d    = GAP;
                    valid_d    = 1'b0;
                    busy_d     = 1'b0;
                    wdog_err_d = 1'b1;
                    rr_ptr_d   = grant_q;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            msg_q      <= SB_MSG_NIL;
            data_q     <= '0;
            ack_q      <= '0;
            grant_q    <= '0;
            rr_ptr_q   <= IDW'(N_REQ - 1);
            wdog_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            msg_q      <= msg_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign SB_TX_msg_valid_o = valid_q;
    assign SB_TX_msg_o       = msg_q;
    assign SB_TX_dataBus_o   = data_q;
    assign req_ack_o         = ack_q;
    assign grant_id_o        = grant_q;
    assign busy_o            = busy_q;
    assign wdog_err_o        = wdog_err_q;

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed bench for sb_tx_arbiter; outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_sb_tx_arbiter;
    import sb_arb_pkg::*;

    localparam int unsigned N = 4;
`ifdef SB_TX_ARB_WDOG_EN
    localparam int unsigned WDOG = 16;
`else
    localparam int unsigned WDOG = 1024;
`endif

    logic              clk_100MHz = 1'b0;
    logic              reset;
    logic              enable_i;
    logic [N-1:0]      req_valid_i;
    SB_msg_t [N-1:0]   req_msg_i;
    logic [N*64-1:0]   req_data_i;
    logic [N-1:0]      req_ack_o;
    SB_msg_t           SB_TX_msg_o;
    logic [63:0]       SB_TX_dataBus_o;
    logic              SB_TX_msg_valid_o;
    logic              SB_TX_msg_sendNextFlag_i;
    logic [1:0]        grant_id_o;
    logic              busy_o;
    logic              wdog_err_o;

    int total = 0;
    int bad   = 0;

    sb_tx_arbiter #(.N_REQ(N), .WDOG_CYCLES(WDOG)) dut (
        .clk_100MHz               (clk_100MHz),
        .reset                    (reset),
        .enable_i                 (enable_i),
        .req_valid_i              (req_valid_i),
        .req_msg_i                (req_msg_i),
        .req_data_i               (req_data_i),
        .req_ack_o                (req_ack_o),
        .SB_TX_msg_o              (SB_TX_msg_o),
        .SB_TX_dataBus_o          (SB_TX_dataBus_o),
        .SB_TX_msg_valid_o        (SB_TX_msg_valid_o),
        .SB_TX_msg_sendNextFlag_i (SB_TX_msg_sendNextFlag_i),
        .grant_id_o               (grant_id_o),
        .busy_o                   (busy_o),
        .wdog_err_o               (wdog_err_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_100MHz);
    endtask

    task automatic set_req(input int i, input SB_msg_t m, input logic [63:0] d);
        req_msg_i[i]          = m;
        req_data_i[i*64 +: 64] = d;
    endtask

    initial begin
        #200000;
        $fatal(1, "FAIL global_timeout observed=running expected=finished");
    end

    initial begin
        int      order [5];
        SB_msg_t msgs  [4];
        order = '{0, 1, 2, 3, 0};
        msgs  = '{SBINIT_DONE_REQ, MBINIT_PARAM_REQ, MBTRAIN_VALVREF_REQ, SBINIT_DONE_RESP};

        reset = 1'b0;
        enable_i = 1'b0;
        req_valid_i = '0;
        req_data_i = '0;
        SB_TX_msg_sendNextFlag_i = 1'b0;
        for (int i = 0; i < int'(N); i++) req_msg_i[i] = SB_MSG_NIL;

        // reset state
        #12;
        chk("rst_valid", 64'(SB_TX_msg_valid_o), 64'd0);
        chk("rst_busy",  64'(busy_o), 64'd0);
        chk("rst_ack",   64'(req_ack_o), 64'd0);
        chk("rst_grant", 64'(grant_id_o), 64'd0);
        chk("rst_msg",   64'(SB_TX_msg_o), 64'(SB_MSG_NIL));
        chk("rst_data",  SB_TX_dataBus_o, 64'd0);
        chk("rst_wdog",  64'(wdog_err_o), 64'd0);

        // single request from requester 0
        step();
        reset = 1'b1;
        enable_i = 1'b1;
        set_req(0, SBINIT_OOR, 64'hA5A5_0000_0000_0001);
        req_valid_i = 4'b0001;
        SB_TX_msg_sendNextFlag_i = 1'b1;
        step();
        chk("single_valid", 64'(SB_TX_msg_valid_o), 64'd1);
        chk("single_msg",   64'(SB_TX_msg_o), 64'(SBINIT_OOR));
        chk("single_data",  SB_TX_dataBus_o, 64'hA5A5_0000_0000_0001);
        chk("single_grant", 64'(grant_id_o), 64'd0);
        chk("single_busy",  64'(busy_o), 64'd1);
        chk("single_noack", 64'(req_ack_o), 64'd0);
        step();
        chk("single_ack",    64'(req_ack_o), 64'b0001);
        chk("single_gapval", 64'(SB_TX_msg_valid_o), 64'd0);
        req_valid_i = '0;
        step();
        chk("single_ackone", 64'(req_ack_o), 64'd0);
        chk("single_idle",   64'(SB_TX_msg_valid_o), 64'd0);

        // async reset in the middle of SEND
        set_req(2, MBINIT_PARAM_REQ, 64'h2222_2222_2222_2222);
        req_valid_i = 4'b0100;
        SB_TX_msg_sendNextFlag_i = 1'b0;
        step();
        chk("arst_pre_valid", 64'(SB_TX_msg_valid_o), 64'd1);
        chk("arst_pre_grant", 64'(grant_id_o), 64'd2);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 64'(SB_TX_msg_valid_o), 64'd0);
        chk("arst_ack",   64'(req_ack_o), 64'd0);
        chk("arst_busy",  64'(busy_o), 64'd0);
        chk("arst_grant", 64'(grant_id_o), 64'd0);
        chk("arst_data",  SB_TX_dataBus_o, 64'd0);
        step();
        reset = 1'b1;

        // all four requesting: fresh pointer means order 0,1,2,3,0
        for (int i = 0; i < int'(N); i++) set_req(i, msgs[i], 64'hD0D0_0000_0000_0000 + 64'(i));
        req_valid_i = 4'b1111;
        SB_TX_msg_sendNextFlag_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("rr%0d_valid", k), 64'(SB_TX_msg_valid_o), 64'd1);
            chk($sformatf("rr%0d_grant", k), 64'(grant_id_o), 64'(order[k]));
            chk($sformatf("rr%0d_data", k), SB_TX_dataBus_o, 64'hD0D0_0000_0000_0000 + 64'(order[k]));
            chk($sformatf("rr%0d_msg", k), 64'(SB_TX_msg_o), 64'(msgs[order[k]]));
            step();
            chk($sformatf("rr%0d_ack", k), 64'(req_ack_o), 64'(4'b0001 << order[k]));
            chk($sformatf("rr%0d_gap", k), 64'(SB_TX_msg_valid_o), 64'd0);
            step();
            chk($sformatf("rr%0d_idle", k), 64'(SB_TX_msg_valid_o), 64'd0);
            chk($sformatf("rr%0d_ack0", k), 64'(req_ack_o), 64'd0);
            if (k == 4) req_valid_i = '0;
        end

        // backpressure on requester 1 for ten cycles
        set_req(1, MBINIT_PARAM_RESP, 64'hBEEF_0000_1111_2222);
        req_valid_i = 4'b0010;
        SB_TX_msg_sendNextFlag_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("bp%0d_valid", i), 64'(SB_TX_msg_valid_o), 64'd1);
            chk($sformatf("bp%0d_data", i), SB_TX_dataBus_o, 64'hBEEF_0000_1111_2222);
            chk($sformatf("bp%0d_noack", i), 64'(req_ack_o), 64'd0);
            if (i == 0) chk("bp_grant", 64'(grant_id_o), 64'd1);
            if (i == 4) set_req(1, MBINIT_PARAM_RESP, 64'h0BAD_0BAD_0BAD_0BAD);
        end
        SB_TX_msg_sendNextFlag_i = 1'b1;
        step();
        chk("bp_ack",   64'(req_ack_o), 64'b0010);
        chk("bp_valid", 64'(SB_TX_msg_valid_o), 64'd0);
        req_valid_i = '0;
        step();
        chk("bp_ackone", 64'(req_ack_o), 64'd0);

        // enable dropped during SEND with requester 1 pending
        set_req(0, SBINIT_OOR, 64'h0000_0000_0000_00E0);
        set_req(1, MBINIT_PARAM_REQ, 64'h0000_0000_0000_00E1);
        req_valid_i = 4'b0001;
        SB_TX_msg_sendNextFlag_i = 1'b0;
        step();
        chk("en_grant", 64'(grant_id_o), 64'd0);
        chk("en_valid", 64'(SB_TX_msg_valid_o), 64'd1);
        enable_i = 1'b0;
        req_valid_i = 4'b0011;
        SB_TX_msg_sendNextFlag_i = 1'b1;
        step();
        chk("en_ack", 64'(req_ack_o), 64'b0001);
        req_valid_i = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("en_hold%0d", i), 64'(SB_TX_msg_valid_o), 64'd0);
        end
        chk("en_hold_ack", 64'(req_ack_o), 64'd0);
        enable_i = 1'b1;
        step();
        chk("en_resume_valid", 64'(SB_TX_msg_valid_o), 64'd1);
        chk("en_resume_grant", 64'(grant_id_o), 64'd1);
        chk("en_resume_data",  SB_TX_dataBus_o, 64'h0000_0000_0000_00E1);
        step();
        chk("en_resume_ack", 64'(req_ack_o), 64'b0010);
        req_valid_i = '0;
        step();

`ifdef SB_TX_ARB_WDOG_EN
        // stalled serializer: watchdog aborts after 16 SEND cycles
        set_req(2, MBTRAIN_VALVREF_REQ, 64'h3333_3333_3333_3333);
        set_req(3, MBTRAIN_VALVREF_RESP, 64'h4444_4444_4444_4444);
        req_valid_i = 4'b1100;
        SB_TX_msg_sendNextFlag_i = 1'b0;
        step();
        chk("wd_grant", 64'(grant_id_o), 64'd2);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("wd%0d_valid", i), 64'(SB_TX_msg_valid_o), 64'd1);
            chk($sformatf("wd%0d_err", i), 64'(wdog_err_o), 64'd0);
            step();
        end
        chk("wd_err",   64'(wdog_err_o), 64'd1);
        chk("wd_noack", 64'(req_ack_o), 64'd0);
        chk("wd_drop",  64'(SB_TX_msg_valid_o), 64'd0);
        step();
        chk("wd_errone", 64'(wdog_err_o), 64'd0);
        step();
        chk("wd_next_grant", 64'(grant_id_o), 64'd3);
        chk("wd_next_valid", 64'(SB_TX_msg_valid_o), 64'd1);
        SB_TX_msg_sendNextFlag_i = 1'b1;
        req_valid_i = '0;
        step();
        chk("wd_next_ack", 64'(req_ack_o), 64'b1000);
        step();
`else
        chk("wdog_tied", 64'(wdog_err_o), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
